// File: rtl/cam_cfg_pkg.sv
// cam_cfg_pkg: shared types, constants and the default register table for the camera init sequencer
package cam_cfg_pkg;

    typedef enum logic [2:0] {POWERUP, LOAD, WRITE, WAIT_END, GAP, DELAY, DONE, ERROR} state_t;

    localparam logic [7:0] DELAY_MARKER = 8'hFF;
    localparam logic [7:0] DEF_SLAVE_ADDR = 8'h42;

    function automatic int max_of(input int a, input int b);
        return a > b ? a : b;
    endfunction

    // Down-counter reload value so a state lasts n cycles (at least one)
    function automatic int load_of(input int n);
        return n > 1 ? n - 1 : 0;
    endfunction

    // OV7670-style RGB565 bring-up; entry 1 waits out the soft reset issued by entry 0
    function automatic logic [15:0] default_entry(input int idx);
        case (idx)
            0: return 16'h1280;
            1: return {DELAY_MARKER, 8'h00};
            2: return 16'h1204;
            3: return 16'h1101;
            4: return 16'h0C00;
            5: return 16'h3E00;
            6: return 16'h0400;
            7: return 16'h40D0;
            8: return 16'h3A04;
            9: return 16'h1418;
            10: return 16'h4FB3;
            11: return 16'h50B3;
            12: return 16'h5100;
            13: return 16'h523D;
            14: return 16'h53A7;
            15: return 16'h54E4;
            16: return 16'h589E;
            17: return 16'h3DC0;
            18: return 16'h1714;
            19: return 16'h1802;
            20: return 16'h3280;
            21: return 16'h1903;
            22: return 16'h1A7B;
            23: return 16'h030A;
            24: return 16'h0F41;
            25: return 16'h1E00;
            26: return 16'h330B;
            27: return 16'h3C78;
            28: return 16'h6900;
            29: return 16'h7400;
            30: return 16'hB084;
            31: return 16'hB10C;
            32: return 16'hB20E;
            default: return 16'h3A04;
        endcase
    endfunction

endpackage

// File: rtl/cam_config_rom.sv
// cam_config_rom: combinational index -> {reg_addr, reg_val} table, replaceable per camera model
module cam_config_rom
    import cam_cfg_pkg::*;
#(
    parameter int LUT_SIZE = 64,
    parameter bit USE_TABLE = 1'b0,
    parameter logic [16*LUT_SIZE-1:0] TABLE = '0,
    localparam int IW = $clog2(LUT_SIZE + 1)
) (
    input  logic [IW-1:0] index,
    output logic [15:0]   entry
);

    // Entry k lives in TABLE[16k +: 16]; the end-of-table index reads as zero
    always_comb begin
        entry = index >= IW'(LUT_SIZE) ? 16'h0000
              : USE_TABLE ? 16'(TABLE >> (16 * int'(index)))
              : default_entry(int'(index));
    end

endmodule

// File: rtl/cam_config_sequencer.sv
// cam_config_sequencer: walks the register table and issues one 3-byte I2C write per entry,
// with retry on NACK/timeout, delay markers, power-up wait and done/error reporting.
module cam_config_sequencer
    import cam_cfg_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR = DEF_SLAVE_ADDR,
    parameter int LUT_SIZE = 64,
    parameter int POWERUP_CYCLES = 1_000_000,
    parameter int GAP_CYCLES = 500,
    parameter int DELAY_CYCLES = 500_000,
    parameter int TIMEOUT_CYCLES = 200_000,
    parameter int MAX_RETRY = 3,
    parameter bit USE_TABLE = 1'b0,
    parameter logic [16*LUT_SIZE-1:0] TABLE = '0,
    localparam int IW = $clog2(LUT_SIZE + 1),
    localparam int CW = max_of(20, $clog2(max_of(max_of(POWERUP_CYCLES, GAP_CYCLES),
                                                 max_of(DELAY_CYCLES, TIMEOUT_CYCLES)) + 1)),
    localparam int RW = max_of(1, $clog2(MAX_RETRY + 1))
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          i2c_end,
    input  logic          i2c_ack,
    output logic [23:0]   i2c_data,
    output logic          i2c_enable,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] fail_index
);

    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [IW-1:0] index;
    logic [RW-1:0] retry;
    logic resend;
    logic [15:0] entry;
    logic cnt_zero, pu_done, success, fail, can_retry;

    cam_config_rom #(.LUT_SIZE(LUT_SIZE), .USE_TABLE(USE_TABLE), .TABLE(TABLE)) u_rom (
        .index(index),
        .entry(entry)
    );

    assign cnt_zero = cnt == '0;
    // The counter is zero out of reset, so power-up loads on its first cycle and ends at one
    assign pu_done = cnt == CW'(1) || POWERUP_CYCLES < 2;
    // END beats a same-cycle timeout
    assign success = state == WAIT_END && i2c_end && i2c_ack;
    assign fail = state == WAIT_END && (i2c_end ? !i2c_ack : cnt_zero);
    assign can_retry = retry < RW'(MAX_RETRY);

    always_comb begin
        nxt = state;
        i2c_enable = state == WRITE || state == WAIT_END;
        busy = state != DONE && state != ERROR;
        done = state == DONE;
        error = state == ERROR;
        case (state)
            POWERUP: nxt = pu_done ? LOAD : POWERUP;
            LOAD: nxt = index == IW'(LUT_SIZE) ? DONE : entry[15:8] == DELAY_MARKER ? DELAY : WRITE;
            WRITE: nxt = WAIT_END;
            WAIT_END: nxt = success ? GAP : fail ? (can_retry ? GAP : ERROR) : WAIT_END;
            GAP: nxt = cnt_zero && !i2c_end ? (resend ? WRITE : LOAD) : GAP;
            DELAY: nxt = cnt_zero ? LOAD : DELAY;
            DONE: nxt = start ? LOAD : DONE;
            ERROR: nxt = start ? LOAD : ERROR;
            default: nxt = POWERUP;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= POWERUP;
            cnt <= '0;
            index <= '0;
            retry <= '0;
            resend <= 1'b0;
            i2c_data <= '0;
            fail_index <= '0;
        end else begin
            state <= nxt;
            if (nxt != state)
                cnt <= nxt == WAIT_END ? CW'(load_of(TIMEOUT_CYCLES))
                     : nxt == GAP ? CW'(load_of(GAP_CYCLES))
                     : nxt == DELAY ? CW'(load_of(DELAY_CYCLES)) : '0;
            else if (state == POWERUP && cnt_zero)
                cnt <= CW'(load_of(POWERUP_CYCLES));
            else if (!cnt_zero)
                cnt <= cnt - 1'b1;
            if (nxt == LOAD && (state == POWERUP || state == DONE || state == ERROR))
                index <= '0;
            else if (success || (state == DELAY && nxt == LOAD))
                index <= index + 1'b1;
            if (state == LOAD && nxt == WRITE) begin
                i2c_data <= {SLAVE_ADDR, entry};
                retry <= '0;
            end else if (fail && can_retry) begin
                retry <= retry + 1'b1;
            end
            if (state == WAIT_END && nxt == GAP)
                resend <= fail;
            if (fail && !can_retry)
                fail_index <= index;
        end
    end

endmodule

// File: doc/cam_config_sequencer.md
Name: cam_config_sequencer

Overview:
- Sits directly upstream of the camera I2C controller and supplies its `I2C_DATA`/`enable` inputs.
- Walks a register-settings table and issues one 3-byte write per entry: slave address, register address, data.
- Waits on the controller's END/ACK, retries NACKed writes, honours delay markers, and reports done/error to the top-level camera init logic.
- Runs automatically after reset; can be re-triggered with `start`.

Parameters:
- `SLAVE_ADDR`, 8'h42, camera write address placed in `i2c_data[23:16]`.
- `LUT_SIZE`, 64, number of table entries (index width = clog2(LUT_SIZE+1)).
- `POWERUP_CYCLES`, 1_000_000, wait after reset release before the first write (20 ms @ 50 MHz).
- `GAP_CYCLES`, 500, minimum idle cycles with `i2c_enable` low between writes.
- `DELAY_CYCLES`, 500_000, wait inserted when an entry's register address is 8'hFF.
- `TIMEOUT_CYCLES`, 200_000, max cycles in WAIT_END before the attempt counts as failed.
- `MAX_RETRY`, 3, retries per entry after the first failed attempt.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; restarts the sequence from index 0 (honoured only in DONE or ERROR)
- `i2c_end`  in  1  END from I2C controller; high = transfer finished
- `i2c_ack`  in  1  ACK from I2C controller; 1 = all bytes acknowledged, sampled while `i2c_end`=1
- `i2c_data`  out  24  {SLAVE_ADDR, reg_addr[7:0], reg_val[7:0]}
- `i2c_enable`  out  1  write request to I2C controller
- `busy`  out  1  sequence in progress
- `done`  out  1  all entries written successfully; level, held until restart or reset
- `error`  out  1  an entry exhausted its retries; level, held until restart or reset
- `fail_index`  out  clog2(LUT_SIZE+1)  index of the failing entry; valid while `error`=1

Behaviour:
- Reset (`reset`=0, async):
  - State = POWERUP.
  - All counters 0.
  - `i2c_enable`=0, `i2c_data`=0, `busy`=1, `done`=0, `error`=0, `fail_index`=0.
- POWERUP: count `POWERUP_CYCLES`, then index:=0 and go to LOAD.
- LOAD (1 cycle):
  - If index==LUT_SIZE → DONE.
  - Otherwise read entry[index]. If reg_addr==8'hFF → DELAY.
  - Otherwise register `i2c_data` and clear the retry count → WRITE.
- WRITE:
  - Drive `i2c_enable`=1 and go to WAIT_END the next cycle.
  - `i2c_data` must be stable from the WRITE cycle until `i2c_enable` falls.
- WAIT_END:
  - Hold `i2c_enable`=1 and count cycles.
  - On the first cycle with `i2c_end`=1: drop `i2c_enable`, sample `i2c_ack`.
    - ack=1 → index+1, go to GAP.
    - ack=0 → failed attempt.
  - If the count reaches `TIMEOUT_CYCLES` with `i2c_end`=0 → drop `i2c_enable`; failed attempt.
- Failed attempt:
  - If retry<MAX_RETRY → retry+1, index unchanged, go to GAP (re-sends the same entry).
  - Otherwise `fail_index`:=index → ERROR.
- GAP:
  - `i2c_enable`=0 for `GAP_CYCLES`.
  - Exit requires both the count done and `i2c_end`=0. Exit goes to LOAD after success, or WRITE after a retry.
  - `i2c_end` stuck high stalls here; it is covered by the next write's timeout only once it clears.
- DELAY: count `DELAY_CYCLES`, index+1, go to LOAD. No I2C traffic.
- DONE: `busy`=0, `done`=1.
- ERROR: `busy`=0, `error`=1.
- Restart: `start`=1 in DONE or ERROR clears `done`/`error`, sets `busy`=1, index:=0, and goes to LOAD. There is no power-up wait on restart.
- `start` is ignored in every other state.
- Simultaneous `i2c_end`=1 and timeout expiry in the same cycle: `i2c_end` wins and ack is evaluated.
- `i2c_end` already high on entry to WAIT_END: not possible, because GAP guarantees it is low first.
- Reset mid-transfer: `i2c_enable` drops immediately (async). The controller is reset by the same system reset.
- Counters: a single shared down-counter, 20 bits minimum and sized to the largest of the cycle parameters. It is reloaded on every state entry.

Decomposition:
- Shared package `cam_cfg_pkg`:
  - state enum (POWERUP, LOAD, WRITE, WAIT_END, GAP, DELAY, DONE, ERROR)
  - `DELAY_MARKER`=8'hFF
  - default `SLAVE_ADDR`
- Sub-module `cam_config_rom`: combinational index→16-bit {reg_addr, reg_val} table, default 16'hFFFF-free entries. It is swappable per camera model. The sequencer holds FSM, counters and retry logic only.

Test Plan:
- Small params (POWERUP=10, GAP=4, DELAY=20, TIMEOUT=50, MAX_RETRY=2), 3-entry ROM {0x1280, 0x1104, 0x8C00}, I2C model ACKs after 30 cycles:
  - `i2c_data` takes 0x421280, 0x421104, 0x428C00 in order.
  - Exactly 3 `enable` pulses.
  - ≥4 low cycles between pulses.
  - `done`=1, `busy`=0.
- Model NACKs entry 1 twice then ACKs → entry 1 sent 3 times; `done`=1, `error`=0.
- Model always NACKs entry 1 → 3 attempts; `error`=1, `fail_index`=1; entry 2 never sent.
- Model never asserts END → each attempt drops `enable` after 50 cycles; 3 attempts, then `error`=1, `fail_index`=0.
- ROM entry 1 = 0xFF00 → no `enable` for 20 cycles between entries 0 and 2; `done`=1.
- Assert `reset`=0 mid-WAIT_END → `enable`=0 in the same cycle. Release → POWERUP wait, then the sequence restarts at entry 0. Pulse `start` in DONE → full re-run with no power-up wait.
